// File: rtl/arm_mem_pkg.sv
// Shared definitions for the MEM-stage SRAM responder.
// Holds the controller state encoding, SRAM geometry, the captured request
// payload and the byte-address to SRAM-word mapping helper.
package arm_mem_pkg;

  localparam int unsigned DATA_BASE = 1024;  // byte address of SRAM word 0
  localparam int unsigned SRAM_AW   = 18;    // SRAM half-word address width
  localparam int unsigned SRAM_DW   = 16;    // SRAM data width
  localparam int unsigned WORD_AW   = SRAM_AW - 1;  // 32-bit word index width

  typedef enum logic [2:0] {
    IDLE,
    LOW,
    HIGH,
    WAIT,
    DONE
  } mem_state_e;

  // Request latched in IDLE; the low store half goes straight to the pins,
  // so only the high half needs to be kept.
  typedef struct packed {
    logic               is_wr;
    logic [WORD_AW-1:0] word;
    logic [SRAM_DW-1:0] wdata_hi;
  } mem_req_t;

  // Word index of a byte address: 32-bit subtract, drop byte offset, truncate.
  function automatic logic [WORD_AW-1:0] word_of(input logic [31:0] addr,
                                                 input logic [31:0] base);
    logic [31:0] off;
    off = addr - base;
    return WORD_AW'(off >> 2);
  endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// Loadable down-counter used to stretch the WAIT state.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   load_i        load load_val_i this cycle (takes priority over dec_i)
//   dec_i         decrement by one, saturating at zero
//   load_val_i    value to load
//   zero_o        registered flag, 1 when the count is zero
module sram_wait_counter #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             dec_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Next count: load wins, otherwise saturating decrement.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  // Count register; zero flag is registered alongside so it is glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      zero_o <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      zero_o <= (cnt_d == '0);
    end
  end

endmodule

// File: rtl/sram_ctrl.sv
// MEM-stage responder: serves one 32-bit load/store per request from a
// 16-bit asynchronous SRAM as two half-word accesses (low half first),
// then holds the pipeline with ready=0 until WAIT_CYCLES have elapsed.
// Optional feature macro: SRAM_READ_REUSE_EN (1-entry read tag; a repeated
// read of the last completed read word skips the SRAM entirely).
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   wr_en, rd_en        store / load request (both set = store)
//   address             byte address
//   write_data          store data
//   read_data           load result, held until the next load completes
//   ready               combinational; 0 freezes the pipeline
//   sram_addr           half-word address to the SRAM
//   sram_dq_out/_oe     write data and pad output enable
//   sram_dq_in          read data from the pad
//   sram_we_n/oe_n      active-low write / output enable
//   sram_ce_n/ub_n/lb_n active-low selects, permanently asserted
module sram_ctrl #(
  parameter int unsigned WAIT_CYCLES = 5,
  parameter int unsigned DATA_BASE   = arm_mem_pkg::DATA_BASE
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wr_en,
  input  logic                             rd_en,
  input  logic [31:0]                      address,
  input  logic [31:0]                      write_data,
  output logic [31:0]                      read_data,
  output logic                             ready,
  output logic [arm_mem_pkg::SRAM_AW-1:0]  sram_addr,
  output logic [arm_mem_pkg::SRAM_DW-1:0]  sram_dq_out,
  output logic                             sram_dq_oe,
  input  logic [arm_mem_pkg::SRAM_DW-1:0]  sram_dq_in,
  output logic                             sram_we_n,
  output logic                             sram_oe_n,
  output logic                             sram_ce_n,
  output logic                             sram_ub_n,
  output logic                             sram_lb_n
);

  import arm_mem_pkg::*;

  // WAIT lasts WAIT_CYCLES-3 cycles; the counter is loaded with one less
  // because the zero flag is already visible in the first WAIT cycle.
  localparam int unsigned WAIT_LEN = (WAIT_CYCLES > 3) ? (WAIT_CYCLES - 3) : 1;
  localparam int unsigned LOAD_VAL = WAIT_LEN - 1;
  localparam int unsigned CNT_W    = (WAIT_CYCLES > 3) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [31:0] BASE_ADDR = 32'(DATA_BASE);

  mem_state_e         state_q;
  mem_req_t           req_q;
  logic [WORD_AW-1:0] req_word_c;
  logic               req_c;
  logic               reuse_hit_c;
  logic               wait_zero;

  assign req_c      = wr_en | rd_en;
  assign req_word_c = word_of(address, BASE_ADDR);

  // Chip, upper and lower byte selects are always active.
  assign sram_ce_n = 1'b0;
  assign sram_ub_n = 1'b0;
  assign sram_lb_n = 1'b0;

  // Idle answers "not busy" only when nothing is requested this cycle.
  always_comb begin
    ready = 1'b0;
    if (state_q == IDLE) begin
      ready = ~req_c;
    end else if (state_q == DONE) begin
      ready = 1'b1;
    end
  end

  sram_wait_counter #(
    .WIDTH (CNT_W)
  ) u_wait_cnt (
    .clk        (clk),
    .rst_n      (rst),
    .load_i     (state_q == HIGH),
    .dec_i      (state_q == WAIT),
    .load_val_i (CNT_W'(LOAD_VAL)),
    .zero_o     (wait_zero)
  );

`ifdef SRAM_READ_REUSE_EN
  logic               tag_vld_q;
  logic [WORD_AW-1:0] tag_word_q;

  // Pure reads only; a combined request is a store and never hits.
  assign reuse_hit_c = rd_en & ~wr_en & tag_vld_q & (tag_word_q == req_word_c);

  // Tag records the last completed read; a store to that word kills it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_vld_q  <= 1'b0;
      tag_word_q <= '0;
    end else if ((state_q == IDLE) && wr_en && (tag_word_q == req_word_c)) begin
      tag_vld_q <= 1'b0;
    end else if ((state_q == DONE) && !req_q.is_wr) begin
      tag_vld_q  <= 1'b1;
      tag_word_q <= req_q.word;
    end
  end
`else
  assign reuse_hit_c = 1'b0;
`endif

  // Access sequencer. SRAM pin values are registered on the edge that enters
  // the state in which they must be seen by the SRAM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      req_q       <= '0;
      read_data   <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_c) begin
            req_q.is_wr    <= wr_en;
            req_q.word     <= req_word_c;
            req_q.wdata_hi <= write_data[31:16];
            if (reuse_hit_c) begin
              state_q <= DONE;
            end else begin
              state_q     <= LOW;
              sram_addr   <= {req_word_c, 1'b0};
              sram_dq_out <= write_data[15:0];
              sram_dq_oe  <= wr_en;
              sram_we_n   <= ~wr_en;
              sram_oe_n   <= wr_en;
            end
          end
        end
        LOW: begin
          if (!req_q.is_wr) begin
            read_data[15:0] <= sram_dq_in;
          end
          state_q     <= HIGH;
          sram_addr   <= {req_q.word, 1'b1};
          sram_dq_out <= req_q.wdata_hi;
        end
        HIGH: begin
          if (!req_q.is_wr) begin
            read_data[31:16] <= sram_dq_in;
          end
          state_q    <= (WAIT_CYCLES == 3) ? DONE : WAIT;
          sram_dq_oe <= 1'b0;
          sram_we_n  <= 1'b1;
          sram_oe_n  <= 1'b1;
        end
        WAIT: begin
          if (wait_zero) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
- Memory-side responder for the pipeline's MEM stage: accepts one 32-bit load/store per request, serves it from external 16-bit asynchronous SRAM as two half-word accesses, and signals completion with `ready`.
- The core freezes all pipeline stages while `ready`=0.
- Sits between the MEM stage (initiator) and the board SRAM pins; replaces the single-cycle data memory.

Parameters:
- WAIT_CYCLES, 5, total cycles `ready` stays low per access; legal range >= 3.
- DATA_BASE, 1024, byte address mapped to SRAM word 0.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- wr_en  in  1  store request from MEM stage.
- rd_en  in  1  load request from MEM stage.
- address  in  32  byte address (ALU result).
- write_data  in  32  store data (val_rm).
- read_data  out  32  load result; valid while `ready`=1 in DONE.
- ready  out  1  0 = access in progress, freeze pipeline.
- sram_addr  out  18  SRAM half-word address.
- sram_dq_out  out  16  data driven to SRAM.
- sram_dq_oe  out  1  1 = drive sram_dq_out onto the pad.
- sram_dq_in  in  16  data from the SRAM pad.
- sram_we_n  out  1  active-low write enable.
- sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n  out  1 each  active-low.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; read_data=0; sram_we_n=1; sram_oe_n=1; sram_dq_oe=0; sram_addr=0; wait counter=0.
  - sram_ce_n, sram_ub_n and sram_lb_n are tied 0.
- `ready` is combinational: `ready` = ~(wr_en|rd_en) in IDLE; 1 in DONE; 0 in all other states.
- Address map:
  - word = (address − DATA_BASE) >> 2, computed as a 32-bit subtract and truncated.
  - Low half is at {word[16:0],1'b0}; high half is at {word[16:0],1'b1}.
  - Little-endian: the low half holds data[15:0].
- Request capture:
  - In IDLE, when wr_en|rd_en, latch the op, address and write_data, then go to LOW.
  - If wr_en and rd_en are both 1, the request is treated as a write.
  - Inputs are ignored after capture until the next IDLE.
- States:
  - IDLE -> LOW on request.
  - LOW (1 cycle): drive the low-half address. On write: we_n=0, oe=1, dq_out=wdata[15:0]. On read: oe_n=0, and capture sram_dq_in into read_data[15:0] at the end of the cycle.
  - HIGH (1 cycle): same as LOW for the high half, using read_data[31:16] / wdata[31:16]. Then go to WAIT, or to DONE if WAIT_CYCLES=3.
  - WAIT: lasts WAIT_CYCLES−3 cycles via a down-counter. SRAM controls are idle (we_n=1, oe_n=1, dq_oe=0).
  - DONE (1 cycle): `ready`=1, and the pipeline advances on this edge. Then go to IDLE.
- Latency: a request seen in cycle 0 gets `ready`=1 in cycle WAIT_CYCLES (default: `ready`=0 for 5 cycles, high in the 6th).
- read_data holds its value until the next read completes; writes never modify it.
- Back-to-back requests: a new request in the IDLE cycle after DONE starts immediately; the bubble is 0 cycles.
- Reset asserted mid-access aborts it: outputs go to reset values and the SRAM write is not completed.

Optional Feature:
- Macro: SRAM_READ_REUSE_EN.
- When defined:
  - A 1-entry tag (word address + valid) records the last completed read.
  - A read in IDLE whose word matches a valid tag goes IDLE -> DONE directly, so `ready` is 0 for 1 cycle and read_data is unchanged.
  - Any write to the same word clears the tag valid bit.
  - Reset clears the tag.
- When undefined: every access takes the full WAIT_CYCLES and no tag logic is present.

Decomposition:
- Shared package arm_mem_pkg holds:
  - the state enum {IDLE, LOW, HIGH, WAIT, DONE};
  - constants DATA_BASE=1024, SRAM_AW=18, SRAM_DW=16.
- One sub-module is natural: sram_wait_counter, a loadable down-counter with an async active-low reset and a `zero` flag, used by the WAIT state.

Test Plan:
- Write then read at address=1024, data=0xDEADBEEF:
  - Write cycles show sram_addr=0 with dq=0xBEEF, then sram_addr=1 with dq=0xDEAD.
  - The read returns 0xDEADBEEF.
  - `ready` is low for 5 cycles on each access.
- Read at address=1032: sram_addr sequence is 4, 5. SRAM model returns 0x1234, 0x5678 -> read_data=0x56781234.
- Back-to-back accesses, wr_en held across DONE to a new address 1028: the second access starts in the cycle after DONE with no idle gap, and the total is 12 cycles.
- Assert rst=0 during HIGH of a write: sram_we_n=1 and sram_dq_oe=0 immediately; the SRAM model holds only the low half; state is IDLE after release.
- Assert wr_en=rd_en=1 at address=1040: a write occurs and read_data is unchanged.
- With SRAM_READ_REUSE_EN defined:
  - A repeated read of 1032 gives `ready` low for 1 cycle.
  - After a write to 1032 the next read takes 5 cycles.
  - With WAIT_CYCLES=3, `ready` is low for 3 cycles.
